// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory
// boot loader.
//   state_t   : loader FSM states
//   HDR_BYTES : bytes in the little-endian word-count header
//   WORD_BYTES: bytes per instruction word
//   mem_wr_t  : one write request to the instruction memory
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_wr_t;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
//   byte_valid/byte_data : host byte stream (host drives)
//   byte_ready           : loader can accept a byte
//   mem_we/addr/wdata    : single-cycle word write to instruction memory
// Modports:
//   master : the loader (consumes the stream, drives the memory write port)
//   slave  : the environment (host link + memory)
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Accepts a byte stream (2-byte LE word count N, then 4*N LE payload bytes),
// assembles 32-bit words and writes them to word indices 0..N-1, holding the
// CPU in reset while a load is in progress.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse, begins a load from IDLE/DONE/ERR
//   bus       : byte stream in, memory write port out (master modport)
//   cpu_hold  : CPU reset hold (high while loading or after a header error)
//   done      : load finished, held until next start/rst
//   error     : header rejected (N == 0 or N > 2^ADDR_W), held until start/rst
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    // Largest legal word count; 17 bits so 2^16 is still representable.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       count_q;
    logic [ADDR_W-1:0] index_q;
    logic [1:0]        bcnt_q;
    logic [31:0]       asm_q;

    logic              accept;
    logic              we;
    logic              hdr_bad;
    logic              last;
    logic [15:0]       hdr_n;
    mem_wr_t           wr;

    // Readiness is a pure state decode, so byte_valid never reaches byte_ready.
    assign accept  = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);

    // Header as it will be once the LEN1 byte lands.
    assign hdr_n   = {bus.byte_data, count_q[7:0]};
    assign hdr_bad = (hdr_n == 16'd0) || ({1'b0, hdr_n} > MAX_WORDS);

    assign last    = (16'(index_q) == (count_q - 16'd1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        we       = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LEN0;
            end
            LEN0: begin
                cpu_hold = 1'b1;
                if (bus.byte_valid) state_d = LEN1;
            end
            LEN1: begin
                cpu_hold = 1'b1;
                if (bus.byte_valid) state_d = hdr_bad ? ERR : DATA;
            end
            DATA: begin
                cpu_hold = 1'b1;
                if (bus.byte_valid && bcnt_q == 2'(WORD_BYTES - 1)) state_d = WRITE;
            end
            WRITE: begin
                cpu_hold = 1'b1;
                we       = 1'b1;
                state_d  = last ? DONE : DATA;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = LEN0;
            end
            ERR: begin
                cpu_hold = 1'b1;
                error    = 1'b1;
                if (start) state_d = LEN0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: header count, byte counter, assembly register, word index.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            index_q <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        index_q <= '0;
                        bcnt_q  <= '0;
                    end
                end
                LEN0: if (bus.byte_valid) count_q[7:0]  <= bus.byte_data;
                LEN1: if (bus.byte_valid) count_q[15:8] <= bus.byte_data;
                DATA: begin
                    if (bus.byte_valid) begin
                        // Shift right so the first byte ends up in [7:0].
                        asm_q  <= {bus.byte_data, asm_q[31:8]};
                        bcnt_q <= bcnt_q + 2'd1;
                    end
                end
                WRITE: if (!last) index_q <= index_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    // Address and data come straight from registers, stable all cycle.
    assign wr = '{we: we, addr: 32'({index_q, 2'b00}), wdata: asm_q};

    assign bus.byte_ready = accept;
    assign bus.mem_we     = wr.we;
    assign bus.mem_addr   = wr.addr;
    assign bus.mem_wdata  = wr.wdata;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_hold, done, error;

    imem_loader_if bus();

    imem_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          done_rises = 0;
    logic        done_prev  = 1'b0;

    // Write monitor: log every memory write; byte_ready must be low in it.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            tests++;
            if (bus.byte_ready !== 1'b0) begin
                fails++;
                $display("FAIL ready_in_write: byte_ready=%b required 0", bus.byte_ready);
            end
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rises++;
        done_prev = done;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one byte and hold it until it transfers; returns at edge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        bus.byte_valid = 1'b0;
        cyc(gap);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %h not accepted", b);
        end
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_rises = 0;
    endtask

    typedef struct packed {
        logic [13:0][7:0] b;
        logic [7:0]       nb;
        logic             gap;
        logic             err;
        logic             dn;
        logic [7:0]       nwr;
        logic [2:0][31:0] w;
    } vec_t;

    function automatic logic [13:0][7:0] pk(
        input logic [7:0] b0 = 0, b1 = 0, b2 = 0, b3 = 0, b4 = 0, b5 = 0, b6 = 0,
        input logic [7:0] b7 = 0, b8 = 0, b9 = 0, b10 = 0, b11 = 0, b12 = 0, b13 = 0);
        logic [13:0][7:0] r;
        r[0] = b0;  r[1] = b1;  r[2] = b2;   r[3] = b3;   r[4] = b4;   r[5] = b5;   r[6] = b6;
        r[7] = b7;  r[8] = b8;  r[9] = b9;   r[10] = b10; r[11] = b11; r[12] = b12; r[13] = b13;
        return r;
    endfunction

    function automatic logic [31:0] img_word(input int i);
        logic [7:0] x;
        x = 8'(i);
        return {x, ~x, x ^ 8'h5A, 8'hC3};
    endfunction

    vec_t  vecs[5];
    string names[5];

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        names[0] = "n2";
        vecs[0]  = '{b: pk(8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00),
                     nb: 8'd10, gap: 1'b0, err: 1'b0, dn: 1'b1, nwr: 8'd2,
                     w: {32'h0, 32'h00B00593, 32'h00A00513}};
        names[1] = "hdr0";
        vecs[1]  = '{b: pk(8'h00, 8'h00), nb: 8'd2, gap: 1'b0, err: 1'b1, dn: 1'b0, nwr: 8'd0, w: '0};
        names[2] = "hdr257";
        vecs[2]  = '{b: pk(8'h01, 8'h01), nb: 8'd2, gap: 1'b0, err: 1'b1, dn: 1'b0, nwr: 8'd0, w: '0};
        names[3] = "n3_nogap";
        vecs[3]  = '{b: pk(8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                           8'h99, 8'hAA, 8'hBB, 8'hCC),
                     nb: 8'd14, gap: 1'b0, err: 1'b0, dn: 1'b1, nwr: 8'd3,
                     w: {32'hCCBBAA99, 32'h88776655, 32'h44332211}};
        names[4] = "n3_gapped";
        vecs[4]  = vecs[3];
        vecs[4].gap = 1'b1;

        // Reset state
        cyc(3);
        @(negedge clk);
        chkb("rst_ready", bus.byte_ready, 1'b0);
        chkb("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chkb("rst_hold", cpu_hold, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_error", error, 1'b0);

        // start coinciding with rst: rst wins, still IDLE
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        chkb("rst_start_ready", bus.byte_ready, 1'b0);
        chkb("rst_start_hold", cpu_hold, 1'b0);

        // Table-driven loads
        for (int v = 0; v < 5; v++) begin
            clear_log();
            pulse_start();
            chkb({names[v], "_hold_load"}, cpu_hold, 1'b1);
            chkb({names[v], "_done_clr"}, done, 1'b0);
            chkb({names[v], "_err_clr"}, error, 1'b0);
            for (int i = 0; i < int'(vecs[v].nb); i++)
                send_byte(vecs[v].b[i], vecs[v].gap ? int'($urandom_range(3, 0)) : 0);
            cyc(6);
            chk({names[v], "_nwr"}, 32'(wa.size()), 32'(vecs[v].nwr));
            for (int i = 0; i < int'(vecs[v].nwr) && i < wa.size(); i++) begin
                chk({names[v], "_addr"}, wa[i], 32'(i * 4));
                chk({names[v], "_data"}, wd[i], vecs[v].w[i]);
            end
            chkb({names[v], "_done"}, done, vecs[v].dn);
            chkb({names[v], "_error"}, error, vecs[v].err);
            chkb({names[v], "_hold"}, cpu_hold, ~vecs[v].dn);
            chk({names[v], "_done_rises"}, 32'(done_rises), 32'(vecs[v].dn));
        end

        // Latency: 4th byte at edge k -> mem_we next cycle; done/hold one later
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        chkb("lat_pre_we", bus.mem_we, 1'b0);
        send_byte(8'h04, 0);
        chkb("lat_we", bus.mem_we, 1'b1);
        chkb("lat_ready", bus.byte_ready, 1'b0);
        chkb("lat_done_lo", done, 1'b0);
        chkb("lat_hold_hi", cpu_hold, 1'b1);
        chk("lat_wdata", bus.mem_wdata, 32'h04030201);
        cyc(1);
        chkb("lat_we_lo", bus.mem_we, 1'b0);
        chkb("lat_done_hi", done, 1'b1);
        chkb("lat_hold_lo", cpu_hold, 1'b0);

        // start during DATA is ignored: the word still completes
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        pulse_start();
        chkb("sdata_ready", bus.byte_ready, 1'b1);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 0);
        cyc(4);
        chk("sdata_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) chk("sdata_data", wd[0], 32'hDDCCBBAA);
        chkb("sdata_done", done, 1'b1);

        // rst mid-load: first word stays written, partial word discarded
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chkb("abort_ready", bus.byte_ready, 1'b0);
        chkb("abort_hold", cpu_hold, 1'b0);
        cyc(4);
        chk("abort_nwr", 32'(wa.size()), 32'd1);
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        cyc(4);
        chk("fresh_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) begin
            chk("fresh_addr", wa[0], 32'h0);
            chk("fresh_data", wd[0], 32'hEFBEADDE);
        end
        chkb("fresh_done", done, 1'b1);

        // Full 256-word image
        clear_log();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = img_word(i);
            send_byte(w[7:0], 0);
            send_byte(w[15:8], 0);
            send_byte(w[23:16], 0);
            send_byte(w[31:24], 0);
        end
        cyc(6);
        chk("full_nwr", 32'(wa.size()), 32'd256);
        begin
            int bad = 0;
            for (int i = 0; i < wa.size(); i++)
                if (wa[i] !== 32'(i * 4) || wd[i] !== img_word(i)) bad++;
            chk("full_content_errs", 32'(bad), 32'd0);
        end
        if (wa.size() > 0) chk("full_last_addr", wa[wa.size() - 1], 32'h3FC);
        chk("full_done_rises", 32'(done_rises), 32'd1);
        chkb("full_done", done, 1'b1);
        chkb("full_hold", cpu_hold, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
